scene_ctrl: RTL and testbench

Game-flow controller that sits directly upstream of `color_mapper`. It owns the `scene` selector (ability select, play, result), the elapsed-seconds `tick` value rendered as three digits, and the per-player ability codes `p1ab`/`p2ab`. It consumes debounced keyboard keycodes and a level-complete flag from game logic.

---
 rtl/scene_ctrl.sv | 149 ++++++++++++++
 tb/tb_scene_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scene_ctrl.sv
// scene_ctrl: game-flow controller feeding color_mapper.
// Sequences ability SELECT -> PLAY -> RESULT, counts elapsed PLAY seconds
// into tick (saturating at TICK_MAX), and latches per-player ability codes.
// Ports:
//   Clk      - system clock, rising edge
//   Reset    - asynchronous active-low reset
//   keycode  - USB HID keycode, 0 = no key
//   done     - level-complete flag, sampled only in PLAY
//   scene    - 0 SELECT, 1 PLAY, 2 RESULT
//   tick     - elapsed whole seconds in PLAY, 0..TICK_MAX
//   p1ab     - player-1 ability, 0 none / 1..4 slot
//   p2ab     - player-2 ability, same encoding
//   timeout  - RESULT reached by tick saturation rather than done
//   start    - one-cycle pulse on the cycle after entering PLAY
module scene_ctrl #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned TICK_MAX = 999
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic        done,
    output logic [7:0]  scene,
    output logic [31:0] tick,
    output logic [7:0]  p1ab,
    output logic [7:0]  p2ab,
    output logic        timeout,
    output logic        start
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [7:0] K_P1_LO = 8'h1E;
    localparam logic [7:0] K_P1_HI = 8'h21;
    localparam logic [7:0] K_P2_LO = 8'h24;
    localparam logic [7:0] K_P2_HI = 8'h27;
    localparam logic [7:0] K_ENTER = 8'h28;
    localparam logic [7:0] K_ESC   = 8'h29;

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_PLAY   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [7:0]    key_prev;
    logic [31:0]   tick_n;
    logic [7:0]    p1ab_n, p2ab_n;
    logic          timeout_n, start_n;
    logic          press, wrap, sat;
    logic [7:0]    slot;

    // Edge-detected key press: a new non-zero keycode.
    assign press = (keycode != key_prev) && (keycode != 8'd0);
    assign wrap  = (presc == PW'(CLK_HZ - 1));
    // Saturation when the pending increment would reach TICK_MAX.
    assign sat   = wrap && ((33'(tick) + 33'd1) >= 33'(TICK_MAX));

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_SELECT;
            presc    <= '0;
            key_prev <= 8'd0;
            tick     <= 32'd0;
            p1ab     <= 8'd0;
            p2ab     <= 8'd0;
            timeout  <= 1'b0;
            start    <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            key_prev <= keycode;
            tick     <= tick_n;
            p1ab     <= p1ab_n;
            p2ab     <= p2ab_n;
            timeout  <= timeout_n;
            start    <= start_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        presc_n   = '0;
        tick_n    = tick;
        p1ab_n    = p1ab;
        p2ab_n    = p2ab;
        timeout_n = timeout;
        start_n   = 1'b0;
        slot      = 8'd0;

        unique case (state)
            S_SELECT: begin
                if (press) begin
                    if (keycode >= K_P1_LO && keycode <= K_P1_HI) begin
                        slot = keycode - (K_P1_LO - 8'd1);
                        if (slot != p2ab) p1ab_n = slot;
                    end else if (keycode >= K_P2_LO && keycode <= K_P2_HI) begin
                        slot = keycode - (K_P2_LO - 8'd1);
                        if (slot != p1ab) p2ab_n = slot;
                    end else if (keycode == K_ENTER && p1ab != 8'd0 && p2ab != 8'd0) begin
                        state_n   = S_PLAY;
                        tick_n    = 32'd0;
                        timeout_n = 1'b0;
                        start_n   = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                presc_n = wrap ? '0 : presc + PW'(1);
                if (done) begin
                    // Completion wins; any increment due this cycle is dropped.
                    state_n   = S_RESULT;
                    timeout_n = 1'b0;
                    presc_n   = '0;
                end else if (sat) begin
                    state_n   = S_RESULT;
                    tick_n    = TICK_MAX;
                    timeout_n = 1'b1;
                    presc_n   = '0;
                end else if (press && keycode == K_ESC) begin
                    state_n = S_SELECT;
                    tick_n  = 32'd0;
                    p1ab_n  = 8'd0;
                    p2ab_n  = 8'd0;
                    presc_n = '0;
                end else if (wrap) begin
                    tick_n = tick + 32'd1;
                end
            end
            S_RESULT: begin
                if (press && keycode == K_ENTER) begin
                    state_n   = S_SELECT;
                    tick_n    = 32'd0;
                    p1ab_n    = 8'd0;
                    p2ab_n    = 8'd0;
                    timeout_n = 1'b0;
                end
            end
            default: state_n = S_SELECT;
        endcase
    end

    assign scene = {6'd0, state};

endmodule

// File: tb/tb_scene_ctrl.sv
// Directed self-checking bench for scene_ctrl with CLK_HZ=10, TICK_MAX=5.
module tb_scene_ctrl;

    logic        Clk;
    logic        Reset;
    logic [7:0]  keycode;
    logic        done;
    logic [7:0]  scene;
    logic [31:0] tick;
    logic [7:0]  p1ab;
    logic [7:0]  p2ab;
    logic        timeout;
    logic        start;

    int checks = 0;
    int errors = 0;
    int pc     = 0;

    scene_ctrl #(.CLK_HZ(10), .TICK_MAX(5)) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .done(done),
        .scene(scene), .tick(tick), .p1ab(p1ab), .p2ab(p2ab),
        .timeout(timeout), .start(start)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Advance PLAY cycle counter (edges since the PLAY-entry edge).
    task automatic to_cycle(input int n);
        while (pc < n) begin
            step();
            pc++;
        end
    endtask

    task automatic press_key(input logic [7:0] k);
        keycode = k;
        step();
        keycode = 8'h00;
        step();
    endtask

    // Enter PLAY from SELECT; pc = 1 on return.
    task automatic enter_play();
        keycode = 8'h28;
        step();
        pc = 0;
        keycode = 8'h00;
        step();
        pc = 1;
    endtask

    initial begin
        Reset   = 1'b0;
        keycode = 8'h00;
        done    = 1'b0;
        #3;
        chk("rst_scene", 32'(scene), 32'd0);
        chk("rst_tick", tick, 32'd0);
        chk("rst_p1ab", 32'(p1ab), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        #9 Reset = 1'b1;
        step();

        // Selection, conflict and gating
        press_key(8'h1F);
        chk("sel_p1_2", 32'(p1ab), 32'd2);
        press_key(8'h25);
        chk("conflict_p2", 32'(p2ab), 32'd0);
        press_key(8'h28);
        chk("gate_enter", 32'(scene), 32'd0);
        keycode = 8'h1E;
        for (int i = 0; i < 20; i++) step();
        keycode = 8'h00;
        step();
        chk("hold_p1_1", 32'(p1ab), 32'd1);
        press_key(8'h1F);
        press_key(8'h26);
        chk("sel_p1", 32'(p1ab), 32'd2);
        chk("sel_p2", 32'(p2ab), 32'd3);

        // Start pulse with Enter held several cycles
        keycode = 8'h28;
        step();
        pc = 0;
        chk("play_scene", 32'(scene), 32'd1);
        chk("start_hi", 32'(start), 32'd1);
        step();
        pc = 1;
        chk("start_lo", 32'(start), 32'd0);
        step();
        pc = 2;
        chk("start_lo2", 32'(start), 32'd0);
        keycode = 8'h00;

        // Counting and saturation
        to_cycle(9);
        chk("tick_c9", tick, 32'd0);
        to_cycle(10);
        chk("tick_c10", tick, 32'd1);
        to_cycle(19);
        chk("tick_c19", tick, 32'd1);
        to_cycle(20);
        chk("tick_c20", tick, 32'd2);
        to_cycle(49);
        chk("tick_c49", tick, 32'd4);
        chk("scene_c49", 32'(scene), 32'd1);
        to_cycle(50);
        chk("tick_c50", tick, 32'd5);
        chk("scene_c50", 32'(scene), 32'd2);
        chk("timeout_c50", 32'(timeout), 32'd1);
        to_cycle(60);
        chk("tick_c60", tick, 32'd5);
        chk("scene_c60", 32'(scene), 32'd2);

        // RESULT ignores other keys and done
        done = 1'b1;
        press_key(8'h29);
        done = 1'b0;
        chk("res_hold_scene", 32'(scene), 32'd2);
        chk("res_hold_to", 32'(timeout), 32'd1);
        press_key(8'h28);
        chk("res_exit_scene", 32'(scene), 32'd0);
        chk("res_exit_tick", tick, 32'd0);
        chk("res_exit_p1", 32'(p1ab), 32'd0);
        chk("res_exit_p2", 32'(p2ab), 32'd0);
        chk("res_exit_to", 32'(timeout), 32'd0);

        // Completion at cycle 25
        press_key(8'h1E);
        press_key(8'h25);
        enter_play();
        to_cycle(24);
        done = 1'b1;
        step();
        pc = 25;
        done = 1'b0;
        chk("done_scene", 32'(scene), 32'd2);
        chk("done_tick", tick, 32'd2);
        chk("done_to", 32'(timeout), 32'd0);
        to_cycle(40);
        chk("done_tick_frz", tick, 32'd2);
        press_key(8'h28);
        chk("done_exit_scene", 32'(scene), 32'd0);
        chk("done_exit_p1", 32'(p1ab), 32'd0);

        // done coincides with 5th wrap
        press_key(8'h1E);
        press_key(8'h25);
        enter_play();
        to_cycle(49);
        done = 1'b1;
        step();
        pc = 50;
        done = 1'b0;
        chk("sim5_scene", 32'(scene), 32'd2);
        chk("sim5_tick", tick, 32'd4);
        chk("sim5_to", 32'(timeout), 32'd0);
        press_key(8'h28);

        // done together with Escape
        press_key(8'h1E);
        press_key(8'h25);
        enter_play();
        to_cycle(14);
        done    = 1'b1;
        keycode = 8'h29;
        step();
        done    = 1'b0;
        keycode = 8'h00;
        step();
        chk("simesc_scene", 32'(scene), 32'd2);
        chk("simesc_tick", tick, 32'd1);
        press_key(8'h28);

        // Escape alone, ability keys ignored in PLAY
        press_key(8'h1E);
        press_key(8'h25);
        enter_play();
        press_key(8'h20);
        chk("play_ab_ign", 32'(p1ab), 32'd1);
        pc = 3;
        to_cycle(12);
        chk("esc_pre_tick", tick, 32'd1);
        press_key(8'h29);
        chk("esc_scene", 32'(scene), 32'd0);
        chk("esc_tick", tick, 32'd0);
        chk("esc_p1", 32'(p1ab), 32'd0);
        chk("esc_p2", 32'(p2ab), 32'd0);

        // Reset mid-play at tick=3
        press_key(8'h1E);
        press_key(8'h25);
        enter_play();
        to_cycle(30);
        chk("pre_rst_tick", tick, 32'd3);
        #2 Reset = 1'b0;
        #1;
        chk("async_scene", 32'(scene), 32'd0);
        chk("async_tick", tick, 32'd0);
        chk("async_p1", 32'(p1ab), 32'd0);
        chk("async_p2", 32'(p2ab), 32'd0);
        chk("async_to", 32'(timeout), 32'd0);
        chk("async_start", 32'(start), 32'd0);
        step();
        Reset = 1'b1;
        step();
        chk("post_rst_scene", 32'(scene), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
